// File: rtl/dmem_access_unit.sv
// dmem_access_unit: load/store sequencer between the core memory stage and SRAM port B
module dmem_access_unit #(
  parameter int ADDR_WIDTH = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_sign,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_bad;
  assign req_bad = (req_size == 2'b11) |
                   ((req_size == 2'b01) & req_addr[0]) |
                   ((req_size == 2'b10) & (|req_addr[1:0])) |
                   (|(req_addr >> ADDR_WIDTH));
  // next-state and request/response register updates
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        size_d  = req_size;
        uns_d   = req_unsigned;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = req_bad;
        state_d = req_bad ? RESP : ACCESS;
      end
      ACCESS: state_d = we_q ? RESP : WAIT;
      WAIT: begin
        rdata_d = mem_rdata;
        state_d = RESP;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // state and register flops with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_read  = rst_n & (state_q == ACCESS) & ~we_q;
  assign mem_write = rst_n & (state_q == ACCESS) & we_q;
  assign mem_sign  = uns_q;
  assign mem_size  = size_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed vector bench with a little-endian SRAM port model
module tb_dmem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_read, mem_write, mem_sign;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] rd_q = '0;
  logic [7:0]  mem [0:4095];
  int          n_rd = 0, n_wr = 0;
  int          n_chk = 0, n_fail = 0;

  dmem_access_unit #(.ADDR_WIDTH(18)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_sign(mem_sign), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rd_q)
  );

  always #5 clk = ~clk;

  // SRAM read slicing: sign (0) / zero (1) extension of byte, half or word
  function automatic logic [31:0] sram_rd(input logic [31:0] a, input logic [1:0] s, input logic u);
    logic [11:0] i;
    logic [7:0]  b0, b1;
    i  = a[11:0];
    b0 = mem[i];
    b1 = mem[i + 12'd1];
    if (s == 2'b00) return u ? {24'b0, b0} : {{24{b0[7]}}, b0};
    if (s == 2'b01) return u ? {16'b0, b1, b0} : {{16{b1[7]}}, b1, b0};
    return {mem[i + 12'd3], mem[i + 12'd2], b1, b0};
  endfunction

  // SRAM port B: writes on strobe, read data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[11:0]] <= mem_wdata[7:0];
      if (mem_size != 2'b00) mem[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
      if (mem_size == 2'b10) begin
        mem[mem_addr[11:0] + 12'd2] <= mem_wdata[23:16];
        mem[mem_addr[11:0] + 12'd3] <= mem_wdata[31:24];
      end
      n_wr <= n_wr + 1;
    end
    if (mem_read) begin
      rd_q <= sram_rd(mem_addr, mem_size, mem_sign);
      n_rd <= n_rd + 1;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;
  vec_t tbl [21];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input int lat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
  endtask

  // bounded wait for rsp_valid; lat counts cycles from the accept edge
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run_vec(input int k);
    int lat, r0, w0;
    vec_t v;
    v = tbl[k];
    r0 = n_rd; w0 = n_wr;
    drive(v.we, v.size, v.uns, v.addr, v.wdata);
    chk($sformatf("v%0d_req_ready", k), {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    chk($sformatf("v%0d_latency", k), lat, v.lat);
    chk($sformatf("v%0d_rdata", k), rsp_rdata, v.rdata);
    chk($sformatf("v%0d_err", k), {31'b0, rsp_err}, {31'b0, v.err});
    chk($sformatf("v%0d_reads", k), n_rd - r0, (!v.err && !v.we) ? 1 : 0);
    chk($sformatf("v%0d_writes", k), n_wr - w0, (!v.err && v.we) ? 1 : 0);
    handshake();
    chk($sformatf("v%0d_rsp_drop", k), {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int lat, w0;
    tbl[0]  = mk(1, 2'b10, 0, 32'h100,      32'hDEADBEEF, 32'h0,        0, 2);
    tbl[1]  = mk(0, 2'b10, 1, 32'h100,      32'h0,        32'hDEADBEEF, 0, 3);
    tbl[2]  = mk(1, 2'b10, 0, 32'h100,      32'h00008000, 32'h0,        0, 2);
    tbl[3]  = mk(0, 2'b00, 0, 32'h101,      32'h0,        32'hFFFFFF80, 0, 3);
    tbl[4]  = mk(0, 2'b00, 1, 32'h101,      32'h0,        32'h00000080, 0, 3);
    tbl[5]  = mk(1, 2'b10, 0, 32'h100,      32'h80011234, 32'h0,        0, 2);
    tbl[6]  = mk(0, 2'b01, 0, 32'h102,      32'h0,        32'hFFFF8001, 0, 3);
    tbl[7]  = mk(0, 2'b01, 1, 32'h102,      32'h0,        32'h00008001, 0, 3);
    tbl[8]  = mk(0, 2'b00, 0, 32'h100,      32'h0,        32'h00000034, 0, 3);
    tbl[9]  = mk(1, 2'b01, 0, 32'h100,      32'hFFFFABCD, 32'h0,        0, 2);
    tbl[10] = mk(1, 2'b00, 0, 32'h103,      32'h0000005A, 32'h0,        0, 2);
    tbl[11] = mk(0, 2'b10, 0, 32'h100,      32'h0,        32'h5A01ABCD, 0, 3);
    tbl[12] = mk(0, 2'b01, 0, 32'h103,      32'h0,        32'h0,        1, 1);
    tbl[13] = mk(1, 2'b10, 0, 32'h102,      32'hFFFFFFFF, 32'h0,        1, 1);
    tbl[14] = mk(0, 2'b11, 0, 32'h100,      32'h0,        32'h0,        1, 1);
    tbl[15] = mk(0, 2'b10, 0, 32'h00040000, 32'h0,        32'h0,        1, 1);
    tbl[16] = mk(1, 2'b10, 0, 32'h0003FFFC, 32'h0BADF00D, 32'h0,        0, 2);
    tbl[17] = mk(0, 2'b10, 0, 32'h0003FFFC, 32'h0,        32'h0BADF00D, 0, 3);
    tbl[18] = mk(0, 2'b10, 0, 32'h100,      32'h0,        32'h5A01ABCD, 0, 3);
    tbl[19] = mk(1, 2'b10, 0, 32'h200,      32'hCAFEF00D, 32'h0,        0, 2);
    tbl[20] = mk(0, 2'b10, 0, 32'h100,      32'h0,        32'h5A01ABCD, 0, 3);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 21; k++) run_vec(k);

    // response backpressure with a competing request held on the input
    drive(0, 2'b10, 1, 32'h100, 32'h0);
    @(posedge clk); #1;
    drive(1, 2'b10, 0, 32'h108, 32'h11223344);
    wait_rsp(lat);
    chk("bp_latency", lat, 3);
    w0 = n_wr;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_rsp_valid", c), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_rdata", c), rsp_rdata, 32'h5A01ABCD);
      chk($sformatf("bp%0d_req_ready", c), {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("bp_no_early_write", n_wr - w0, 0);
    handshake();
    chk("bp_idle_req_ready", {31'b0, req_ready}, 32'd1);
    chk("bp_idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    chk("bp2_latency", lat, 2);
    chk("bp2_err", {31'b0, rsp_err}, 32'd0);
    chk("bp2_write", n_wr - w0, 1);
    handshake();
    drive(0, 2'b10, 0, 32'h108, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    chk("bp2_readback", rsp_rdata, 32'h11223344);
    handshake();

    // reset asserted while a store sits in ACCESS
    drive(1, 2'b10, 0, 32'h200, 32'h12345678);
    w0 = n_wr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rs_access_write", {31'b0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_gated_write", {31'b0, mem_write}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rs_no_write", n_wr - w0, 0);
    chk("rs_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rs_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rs_req_ready", {31'b0, req_ready}, 32'd1);
    drive(0, 2'b10, 0, 32'h200, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    chk("rs_prior_value", rsp_rdata, 32'hCAFEF00D);

    // reset while a load response is pending discards it
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rr_rsp_rdata", rsp_rdata, 32'd0);
    chk("rr_req_ready", {31'b0, req_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
